// File: rtl/frac_clk_pkg.sv
// Shared types and constants for the fractional-N clock-enable generator.
//   ch_state_e    : per-channel NCO state
//   ACC_W_DEF     : default accumulator width
//   INC_OPL2_*    : OPL2 master and sample tick increments on a 96 MHz, 32-bit basis
package frac_clk_pkg;

  localparam int unsigned ACC_W_DEF = 32;

  localparam logic [31:0] INC_OPL2_MCLK = 32'd160146132;
  localparam logic [31:0] INC_OPL2_FS   = 32'd2224252;

  typedef enum logic {
    CH_IDLE,
    CH_RUN
  } ch_state_e;

endpackage

// File: rtl/frac_clk_en_gen_if.sv
// Increment-write channel of the clock-enable generator.
//   cfg_valid : write request
//   cfg_ready : write acceptance (transfer on cfg_valid && cfg_ready)
//   cfg_ch    : target channel
//   cfg_inc   : new increment
interface frac_clk_en_gen_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ACC_W  = 32
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;

  modport master (output cfg_valid, output cfg_ch, output cfg_inc, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_ch, input  cfg_inc, output cfg_ready);

endinterface

// File: rtl/frac_clk_en_gen_nco_ch.sv
// One NCO channel: phase accumulator, active/pending increment and run FSM.
//   clk, reset_n : clock, synchronous active-low reset
//   locked_i     : generator settled; channel may only start when high
//   run_i        : run request level
//   sync_i       : zero the phase of a running channel
//   wr_i         : accepted increment write for this channel
//   wr_inc_i     : increment carried by the write
//   en_o         : registered single-cycle enable, one cycle after the wrapping add
//   busy_o       : a written increment waits to be applied
module frac_nco_ch
  import frac_clk_pkg::*;
#(
  parameter int unsigned       ACC_W   = 32,
  parameter logic [ACC_W-1:0]  DEF_INC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             locked_i,
  input  logic             run_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] wr_inc_i,
  output logic             en_o,
  output logic             busy_o
);

  ch_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             en_q, en_d;
  logic [ACC_W:0]   sum_c;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
      acc_q   <= '0;
      inc_q   <= DEF_INC;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
    end
  end

  // Next state; a pending increment only lands on a period boundary (carry, sync or idle)
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    sum_c   = {1'b0, acc_q} + {1'b0, inc_q};

    case (state_q)
      CH_IDLE: begin
        acc_d = '0;
        if (busy_q) begin
          inc_d  = pend_q;
          busy_d = 1'b0;
        end
        if (run_i && locked_i) state_d = CH_RUN;
      end
      CH_RUN: begin
        if (!run_i) begin
          state_d = CH_IDLE;
          acc_d   = '0;
        end else if (sync_i) begin
          acc_d = '0;
          if (busy_q) begin
            inc_d  = pend_q;
            busy_d = 1'b0;
          end
        end else begin
          acc_d = sum_c[ACC_W-1:0];
          en_d  = sum_c[ACC_W];
          if (sum_c[ACC_W] && busy_q) begin
            inc_d  = pend_q;
            busy_d = 1'b0;
          end
        end
      end
      default: state_d = CH_IDLE;
    endcase

    // Writes are only accepted when not busy, so they never collide with an apply
    if (wr_i) begin
      pend_d = wr_inc_i;
      busy_d = 1'b1;
    end
  end

  assign en_o   = en_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/frac_clk_en_gen.sv
// Multi-channel fractional-N clock-enable generator.
//   clk, reset_n : fabric clock, synchronous active-low reset
//   run_i        : per-channel run request
//   sync_i       : zero the phase of all running channels
//   cfg          : increment write channel (slave side)
//   en_o         : per-channel single-cycle clock enables
//   locked_o     : generator settled, stays high until reset
//   busy_o       : per-channel pending increment
module frac_clk_en_gen
  import frac_clk_pkg::*;
#(
  parameter int unsigned              NUM_CH      = 2,
  parameter int unsigned              ACC_W       = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_INC     = {INC_OPL2_FS, INC_OPL2_MCLK},
  parameter int unsigned              LOCK_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] run_i,
  input  logic              sync_i,
  frac_clk_en_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] en_o,
  output logic              locked_o,
  output logic [NUM_CH-1:0] busy_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             sel_busy_c;
  logic             cfg_acc_c;

  // Lock counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // Count from reset release; freeze once locked
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      lock_cnt_d = lock_cnt_q + LCK_W'(1);
      if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) locked_d = 1'b1;
    end
  end

  // Busy flag of the addressed channel; out-of-range channels read as busy
  always_comb begin
    sel_busy_c = 1'b1;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (cfg.cfg_ch == CH_W'(c)) sel_busy_c = busy_o[c];
    end
  end

  assign cfg.cfg_ready = locked_q && !sel_busy_c;
  assign cfg_acc_c     = cfg.cfg_valid && cfg.cfg_ready;
  assign locked_o      = locked_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    frac_nco_ch #(
      .ACC_W   (ACC_W),
      .DEF_INC (DEF_INC[c*ACC_W +: ACC_W])
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .locked_i (locked_q),
      .run_i    (run_i[c]),
      .sync_i   (sync_i),
      .wr_i     (cfg_acc_c && (cfg.cfg_ch == CH_W'(c))),
      .wr_inc_i (cfg.cfg_inc),
      .en_o     (en_o[c]),
      .busy_o   (busy_o[c])
    );
  end

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Self-checking bench for frac_clk_en_gen: directed scenarios plus random traffic on an
// 8-bit, 2-channel instance against a phase-accumulation model, and a long-run rate check
// on a default (32-bit OPL2) instance.
module tb_frac_clk_en_gen;

  localparam int unsigned LCK  = 4;
  localparam int          MODN = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] run;
  logic       sync;
  logic [1:0] en, busy;
  logic       locked;

  logic       rst32_n;
  logic [1:0] en32, busy32;
  logic       locked32;

  always #5 clk = ~clk;

  frac_clk_en_gen_if #(.NUM_CH(2), .ACC_W(8))  cif ();
  frac_clk_en_gen_if #(.NUM_CH(2), .ACC_W(32)) cif32 ();

  frac_clk_en_gen #(
    .NUM_CH(2), .ACC_W(8), .DEF_INC({8'd32, 8'd64}), .LOCK_CYCLES(LCK)
  ) u_dut (
    .clk(clk), .reset_n(rst_n), .run_i(run), .sync_i(sync), .cfg(cif),
    .en_o(en), .locked_o(locked), .busy_o(busy)
  );

  frac_clk_en_gen u_dut32 (
    .clk(clk), .reset_n(rst32_n), .run_i(2'b11), .sync_i(1'b0), .cfg(cif32),
    .en_o(en32), .locked_o(locked32), .busy_o(busy32)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int p0[$];
  int p1[$];

  // Reference model: phase in [0, MODN), pulse whenever accumulated phase crosses MODN
  int def_inc[2] = '{64, 32};
  int m_phase[2], m_inc[2], m_pend[2];
  bit m_run[2], m_busy[2], m_en[2];
  int m_cyc;
  bit m_locked;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_phase[c] = 0; m_inc[c] = def_inc[c]; m_pend[c] = 0;
      m_run[c] = 0; m_busy[c] = 0; m_en[c] = 0;
    end
    m_cyc = 0; m_locked = 0;
  endtask

  task automatic model_edge();
    bit accept, lk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lk     = m_locked;
    accept = cif.cfg_valid && lk && !m_busy[cif.cfg_ch];
    for (int c = 0; c < 2; c++) begin
      m_en[c] = 0;
      if (!m_run[c]) begin
        m_phase[c] = 0;
        if (m_busy[c]) begin m_inc[c] = m_pend[c]; m_busy[c] = 0; end
        if (run[c] && lk) m_run[c] = 1;
      end else if (!run[c]) begin
        m_run[c] = 0; m_phase[c] = 0;
      end else if (sync) begin
        m_phase[c] = 0;
        if (m_busy[c]) begin m_inc[c] = m_pend[c]; m_busy[c] = 0; end
      end else begin
        m_phase[c] += m_inc[c];
        if (m_phase[c] >= MODN) begin
          m_phase[c] -= MODN;
          m_en[c] = 1;
          if (m_busy[c]) begin m_inc[c] = m_pend[c]; m_busy[c] = 0; end
        end
      end
      if (accept && int'(cif.cfg_ch) == c) begin
        m_pend[c] = int'(cif.cfg_inc);
        m_busy[c] = 1;
      end
    end
    m_cyc++;
    if (m_cyc >= int'(LCK)) m_locked = 1;
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after
  task automatic tick();
    #1;
    check("cfg_ready", cif.cfg_ready, m_locked && !m_busy[cif.cfg_ch]);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("en_o", en, {m_en[1], m_en[0]});
    check("busy_o", busy, {m_busy[1], m_busy[0]});
    check("locked_o", locked, m_locked);
    if (en[0]) p0.push_back(cyc);
    if (en[1]) p1.push_back(cyc);
    sync          = 1'b0;
    cif.cfg_valid = 1'b0;
  endtask

  task automatic wr(input int ch, input int val);
    cif.cfg_ch    = 1'(ch);
    cif.cfg_inc   = 8'(val);
    cif.cfg_valid = 1'b1;
    tick();
    check("wr_busy", busy[ch], 1);
  endtask

  task automatic wait_applied(input int ch);
    int n = 0;
    while (busy[ch] && n < 600) begin tick(); n++; end
    check("busy_clear", busy[ch], 0);
  endtask

  // Long-run pulse counters on the 32-bit instance
  longint lk32 = 0, c32_0 = 0, c32_1 = 0;
  always @(negedge clk) begin
    if (rst32_n && locked32) begin
      lk32++;
      c32_0 += longint'(en32[0]);
      c32_1 += longint'(en32[1]);
    end
  end

  initial begin
    int     s, n, r;
    int     exp_gap[6];
    longint e0, e1, d0, d1;

    rst_n = 1'b0; rst32_n = 1'b0; run = 2'b00; sync = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_ch = '0; cif.cfg_inc = '0;
    cif32.cfg_valid = 1'b0; cif32.cfg_ch = '0; cif32.cfg_inc = '0;
    model_reset();
    tick(); tick();
    check("rst_en", en, 0);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cif.cfg_ready, 0);

    // Lock: high after the 4th edge; no enable before
    rst_n = 1'b1; rst32_n = 1'b1; run = 2'b11;
    for (int i = 1; i <= int'(LCK); i++) begin
      if (i < int'(LCK)) begin
        #1 check("pre_lock_ready", cif.cfg_ready, 0);
      end
      tick();
      check("lock_en_quiet", en, 0);
      check("lock_time", locked, (i >= int'(LCK)) ? 1 : 0);
    end

    // inc=64 -> period 4
    p0.delete();
    repeat (20) tick();
    check("inc64_npulse", (p0.size() >= 3) ? 1 : 0, 1);
    for (int i = 1; i < p0.size(); i++) check("inc64_gap", p0[i] - p0[i-1], 4);

    // inc=96 from zero phase -> 3,3,2 repeating
    wr(0, 96);
    wait_applied(0);
    sync = 1'b1; tick(); s = cyc;
    p0.delete();
    repeat (24) tick();
    exp_gap = '{3, 3, 2, 3, 3, 2};
    check("inc96_npulse", (p0.size() >= 6) ? 1 : 0, 1);
    for (int i = 0; i < 6 && i < p0.size(); i++)
      check("inc96_gap", p0[i] - ((i == 0) ? s : p0[i-1]), exp_gap[i]);

    // Mid-period write: current period finishes at old rate
    wr(0, 64);
    wait_applied(0);
    n = 0;
    while (!en[0] && n < 20) begin tick(); n++; end
    check("midwr_seen_pulse", en[0], 1);
    p0.delete(); p0.push_back(cyc);
    tick();
    wr(0, 128);
    #1 check("midwr_ready_low", cif.cfg_ready, 0);
    n = 0;
    while (p0.size() < 3 && n < 20) begin tick(); n++; end
    check("midwr_npulse", p0.size(), 3);
    if (p0.size() >= 3) begin
      check("midwr_gap_old", p0[1] - p0[0], 4);
      check("midwr_gap_new", p0[2] - p0[1], 2);
    end

    // Sync with ch0=64, ch1=32: pulses 4 and 8 cycles later
    wr(0, 64);
    wait_applied(0);
    sync = 1'b1; tick(); s = cyc;
    p0.delete(); p1.delete();
    repeat (10) tick();
    check("sync_p0", (p0.size() > 0) ? p0[0] - s : -1, 4);
    check("sync_p1", (p1.size() > 0) ? p1[0] - s : -1, 8);

    // Drop run_i[1] exactly on its carry cycle
    n = 0;
    while (!(m_run[1] && m_phase[1] + m_inc[1] >= MODN) && n < 20) begin tick(); n++; end
    check("drop_found_carry", (n < 20) ? 1 : 0, 1);
    run[1] = 1'b0;
    tick();
    check("drop_no_pulse", en[1], 0);
    repeat (3) tick();
    run[1] = 1'b1;
    tick(); r = cyc;
    p1.delete();
    n = 0;
    while (p1.size() == 0 && n < 20) begin tick(); n++; end
    check("rerun_first_pulse", (p1.size() > 0) ? p1[0] - r : -1, 8);

    // Random traffic, including resets, writes while unlocked and boundary increments
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) run[$urandom_range(1)] ^= 1'b1;
      sync = ($urandom_range(49) == 0);
      if ($urandom_range(5) == 0) begin
        cif.cfg_valid = 1'b1;
        cif.cfg_ch    = 1'($urandom_range(1));
        case ($urandom_range(3))
          0:       cif.cfg_inc = 8'($urandom_range(1) * 255);
          1:       cif.cfg_inc = 8'(128 + $urandom_range(127));
          default: cif.cfg_inc = 8'($urandom_range(255));
        endcase
      end
      rst_n = ($urandom_range(999) != 0);
      tick();
    end
    rst_n = 1'b1;

    // Long-run rate on the OPL2 defaults: rate = inc / 2^32 per cycle
    repeat (50000) @(posedge clk);
    #2;
    e0 = (lk32 * 64'd160146132) >> 32;
    e1 = (lk32 * 64'd2224252) >> 32;
    d0 = c32_0 - e0;
    d1 = c32_1 - e1;
    check("rate32_ch0", (d0 >= -2 && d0 <= 2) ? 1 : 0, 1);
    check("rate32_ch1", (d1 >= -2 && d1 <= 2) ? 1 : 0, 1);
    check("rate32_active", (c32_0 > 1000) ? 1 : 0, 1);

    // Reset mid-run on the 32-bit instance
    rst32_n = 1'b0;
    @(posedge clk); #1;
    check("rst32_en", en32, 0);
    check("rst32_locked", locked32, 0);
    check("rst32_busy", busy32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
